alarm_controller: RTL and testbench

Alarm unit sitting directly downstream of the 24-hour BCD clock. Consumes the clock's `hh`/`mm`/`ss` BCD outputs and its one-second enable, stores a programmable alarm time, and drives a ring output through an IDLE/RINGING/SNOOZE state machine. It provides automatic ring timeout and a bounded snooze count.

---
 rtl/alarm_pkg.sv | 27 ++
 rtl/alarm_controller_if.sv | 33 +++
 rtl/alarm_tick_timer.sv | 31 +++
 rtl/alarm_controller.sv | 118 +++++++++++
 tb/tb_alarm_controller.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared types and constants for the alarm controller
// Purpose: FSM state enum, BCD limit constants, reset alarm time and the
//          alarm-time validation helper.
// Ports:   none (package).
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } alarm_state_t;

  localparam logic [7:0] HH_MAX   = 8'h23;
  localparam logic [7:0] MM_MAX   = 8'h59;
  localparam logic [7:0] SS_ZERO  = 8'h00;
  localparam logic [7:0] RESET_HH = 8'h06;
  localparam logic [7:0] RESET_MM = 8'h00;

  // The range compares alone are not enough: 8'h1A is below 8'h23 but is not
  // BCD, so every nibble is checked as well.
  function automatic logic bcd_time_ok(input logic [7:0] h, input logic [7:0] m);
    return (h[7:4] <= 4'd9) && (h[3:0] <= 4'd9) &&
           (m[7:4] <= 4'd9) && (m[3:0] <= 4'd9) &&
           (h <= HH_MAX) && (m <= MM_MAX);
  endfunction

endpackage

// File: rtl/alarm_controller_if.sv
// rtl/alarm_controller_if.sv - signal bundle between time source/host and alarm
// Purpose: groups the time inputs, alarm programming/control inputs and the
//          alarm status outputs.
// Ports:   master drives tick/hh/mm/ss/arm/set_alarm/set_hh/set_mm/snooze/stop
//          and observes alarm_hh/alarm_mm/ring/snoozing/set_err; slave is the
//          alarm controller side.
interface alarm_controller_if;
  logic       tick;
  logic [7:0] hh;
  logic [7:0] mm;
  logic [7:0] ss;
  logic       arm;
  logic       set_alarm;
  logic [7:0] set_hh;
  logic [7:0] set_mm;
  logic       snooze;
  logic       stop;
  logic [7:0] alarm_hh;
  logic [7:0] alarm_mm;
  logic       ring;
  logic       snoozing;
  logic       set_err;

  modport master (
    output tick, hh, mm, ss, arm, set_alarm, set_hh, set_mm, snooze, stop,
    input  alarm_hh, alarm_mm, ring, snoozing, set_err
  );

  modport slave (
    input  tick, hh, mm, ss, arm, set_alarm, set_hh, set_mm, snooze, stop,
    output alarm_hh, alarm_mm, ring, snoozing, set_err
  );
endinterface

// File: rtl/alarm_tick_timer.sv
// rtl/alarm_tick_timer.sv - loadable one-second down-counter
// Purpose: counts ticks down from a loaded value; expire flags the tick that
//          consumes the last count.
// Ports:   clk, reset (async, active-high), load/load_val (load wins over
//          tick), tick (decrement enable), expire (tick && cnt==1).
module alarm_tick_timer #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (tick && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expire = tick && (cnt == W'(1));

endmodule

// File: rtl/alarm_controller.sv
// rtl/alarm_controller.sv - alarm unit downstream of the 24-hour BCD clock
// Purpose: stores a validated alarm time, detects the alarm minute and runs
//          the IDLE/RINGING/SNOOZE machine with ring timeout and snooze limit.
// Ports:   clk, reset (async, active-high), bus (alarm_controller_if.slave):
//          time inputs, arm/set/snooze/stop controls, alarm_hh/alarm_mm,
//          ring, snoozing, set_err (all outputs registered).
module alarm_controller
  import alarm_pkg::*;
#(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_MINUTES = 5,
  parameter int MAX_SNOOZES    = 3
) (
  input  logic               clk,
  input  logic               reset,
  alarm_controller_if.slave  bus
);

  localparam int SNOOZE_TICKS = SNOOZE_MINUTES * 60;
  localparam int TMAX = (RING_SECONDS > SNOOZE_TICKS) ? RING_SECONDS : SNOOZE_TICKS;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int CW   = (MAX_SNOOZES > 0) ? $clog2(MAX_SNOOZES + 1) : 1;

  alarm_state_t state, next_state;
  logic [7:0]   alarm_hh_q, alarm_mm_q;
  logic [CW-1:0] snooze_cnt;
  logic         ring_q, snoozing_q, set_err_q;

  logic          load_ok, match, expire;
  logic          tmr_load, cnt_inc, cnt_clr;
  logic [TW-1:0] tmr_val;

  assign load_ok = bus.set_alarm && bcd_time_ok(bus.set_hh, bus.set_mm);
  assign match   = bus.tick && bus.arm && (bus.hh == alarm_hh_q) &&
                   (bus.mm == alarm_mm_q) && (bus.ss == SS_ZERO);

  alarm_tick_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tick     (bus.tick),
    .expire   (expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Priority: arm low, valid load, stop, timer expiry, snooze.
  always_comb begin
    next_state = state;
    if (!bus.arm) begin
      next_state = IDLE;
    end else if (load_ok) begin
      next_state = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (match) next_state = RINGING;
        RINGING: begin
          if (bus.stop || expire)                            next_state = IDLE;
          else if (bus.snooze && (snooze_cnt < CW'(MAX_SNOOZES))) next_state = SNOOZE;
        end
        SNOOZE: begin
          if (bus.stop)   next_state = IDLE;
          else if (expire) next_state = RINGING;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // Timer and snooze-count controls follow from the transition taken. The
  // count is held at zero throughout IDLE, so every new event starts fresh.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = TW'(RING_SECONDS);
    cnt_inc  = 1'b0;
    cnt_clr  = (next_state == IDLE);
    if (next_state == RINGING && state != RINGING) begin
      tmr_load = 1'b1;
    end
    if (next_state == SNOOZE && state == RINGING) begin
      tmr_load = 1'b1;
      tmr_val  = TW'(SNOOZE_TICKS);
      cnt_inc  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alarm_hh_q <= RESET_HH;
      alarm_mm_q <= RESET_MM;
      snooze_cnt <= '0;
      ring_q     <= 1'b0;
      snoozing_q <= 1'b0;
      set_err_q  <= 1'b0;
    end else begin
      if (load_ok) begin
        alarm_hh_q <= bus.set_hh;
        alarm_mm_q <= bus.set_mm;
      end
      if (cnt_clr)      snooze_cnt <= '0;
      else if (cnt_inc) snooze_cnt <= snooze_cnt + CW'(1);
      ring_q     <= (next_state == RINGING);
      snoozing_q <= (next_state == SNOOZE);
      set_err_q  <= bus.set_alarm && !load_ok;
    end
  end

  assign bus.alarm_hh = alarm_hh_q;
  assign bus.alarm_mm = alarm_mm_q;
  assign bus.ring     = ring_q;
  assign bus.snoozing = snoozing_q;
  assign bus.set_err  = set_err_q;

endmodule

// File: tb/tb_alarm_controller.sv
// tb/tb_alarm_controller.sv - directed self-checking bench for alarm_controller
module tb_alarm_controller;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  int   tsec = 0;

  alarm_controller_if bus ();

  alarm_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic r, input logic s);
    chk({tag, ".ring"}, {7'd0, bus.ring}, {7'd0, r});
    chk({tag, ".snoozing"}, {7'd0, bus.snoozing}, {7'd0, s});
  endtask

  // Inputs are driven at the negedge, one posedge passes, pulses are cleared.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    bus.tick      = 1'b0;
    bus.set_alarm = 1'b0;
    bus.snooze    = 1'b0;
    bus.stop      = 1'b0;
  endtask

  task automatic do_tick();
    bus.hh   = bcd(tsec / 3600);
    bus.mm   = bcd((tsec / 60) % 60);
    bus.ss   = bcd(tsec % 60);
    bus.tick = 1'b1;
    step();
    tsec = (tsec + 1) % 86400;
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic load(input logic [7:0] h, input logic [7:0] m);
    bus.set_hh    = h;
    bus.set_mm    = m;
    bus.set_alarm = 1'b1;
    step();
  endtask

  // Lands on 07:30:00 as the second tick, so ring is high after it.
  task automatic reach_alarm();
    tsec = 7 * 3600 + 29 * 60 + 59;
    do_tick();
    do_tick();
  endtask

  initial begin
    reset = 1'b1;
    bus.tick = 1'b0; bus.hh = 8'h00; bus.mm = 8'h00; bus.ss = 8'h00;
    bus.arm = 1'b0; bus.set_alarm = 1'b0; bus.set_hh = 8'h00; bus.set_mm = 8'h00;
    bus.snooze = 1'b0; bus.stop = 1'b0;
    @(negedge clk);
    chk("rst.alarm_hh", bus.alarm_hh, 8'h06);
    chk("rst.alarm_mm", bus.alarm_mm, 8'h00);
    chk_out("rst", 1'b0, 1'b0);
    chk("rst.set_err", {7'd0, bus.set_err}, 8'd0);
    reset = 1'b0;
    @(negedge clk);

    load(8'h07, 8'h30);
    chk("load.alarm_hh", bus.alarm_hh, 8'h07);
    chk("load.alarm_mm", bus.alarm_mm, 8'h30);
    chk("load.set_err", {7'd0, bus.set_err}, 8'd0);
    bus.arm = 1'b1;

    // First event: 07:29:58, 07:29:59, 07:30:00
    tsec = 7 * 3600 + 29 * 60 + 58;
    do_tick();
    chk_out("pre58", 1'b0, 1'b0);
    do_tick();
    chk_out("pre59", 1'b0, 1'b0);
    do_tick();
    chk_out("match", 1'b1, 1'b0);
    do_ticks(59);
    chk_out("ring59", 1'b1, 1'b0);
    do_tick();
    chk_out("autooff", 1'b0, 1'b0);

    // Snooze three times, fourth is ignored
    reach_alarm();
    chk_out("ev2", 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      bus.snooze = 1'b1;
      step();
      chk_out($sformatf("snz%0d", k), 1'b0, 1'b1);
      do_ticks(299);
      chk_out($sformatf("snz%0d.299", k), 1'b0, 1'b1);
      do_tick();
      chk_out($sformatf("snz%0d.resume", k), 1'b1, 1'b0);
    end
    bus.snooze = 1'b1;
    step();
    chk_out("snz4.ignored", 1'b1, 1'b0);
    bus.snooze = 1'b1;
    bus.stop   = 1'b1;
    step();
    chk_out("stop+snooze", 1'b0, 1'b0);

    // Count was reset, so snooze works again; then arm low during snooze
    reach_alarm();
    chk_out("ev3", 1'b1, 1'b0);
    bus.snooze = 1'b1;
    step();
    chk_out("ev3.snooze", 1'b0, 1'b1);
    bus.arm = 1'b0;
    step();
    chk_out("disarm", 1'b0, 1'b0);
    do_ticks(301);
    chk_out("disarm.later", 1'b0, 1'b0);
    bus.arm = 1'b1;
    do_ticks(3);
    chk_out("rearm", 1'b0, 1'b0);

    // Rejected and boundary loads
    load(8'h24, 8'h00);
    chk("err_hh.set_err", {7'd0, bus.set_err}, 8'd1);
    chk("err_hh.alarm_hh", bus.alarm_hh, 8'h07);
    step();
    chk("err_hh.pulse", {7'd0, bus.set_err}, 8'd0);
    load(8'h12, 8'h5A);
    chk("err_mm.set_err", {7'd0, bus.set_err}, 8'd1);
    chk("err_mm.alarm_mm", bus.alarm_mm, 8'h30);
    load(8'h1A, 8'h00);
    chk("err_nib.set_err", {7'd0, bus.set_err}, 8'd1);
    chk("err_nib.alarm_hh", bus.alarm_hh, 8'h07);
    load(8'h23, 8'h59);
    chk("max.set_err", {7'd0, bus.set_err}, 8'd0);
    chk("max.alarm_hh", bus.alarm_hh, 8'h23);
    chk("max.alarm_mm", bus.alarm_mm, 8'h59);
    load(8'h07, 8'h30);
    chk("back.alarm_mm", bus.alarm_mm, 8'h30);

    // Expiry and snooze on the same tick: expiry wins
    reach_alarm();
    chk_out("ev4", 1'b1, 1'b0);
    do_ticks(59);
    bus.snooze = 1'b1;
    do_tick();
    chk_out("expire+snooze", 1'b0, 1'b0);

    // Load in the match cycle suppresses the ring
    tsec = 7 * 3600 + 29 * 60 + 59;
    do_tick();
    bus.set_hh = 8'h07;
    bus.set_mm = 8'h30;
    bus.set_alarm = 1'b1;
    do_tick();
    chk_out("load+match", 1'b0, 1'b0);

    // Asynchronous reset mid-ring
    reach_alarm();
    chk_out("ev5", 1'b1, 1'b0);
    load(8'h07, 8'h31);
    chk("ev5.load", bus.alarm_mm, 8'h31);
    chk_out("ev5.loadidle", 1'b0, 1'b0);
    load(8'h07, 8'h30);
    reach_alarm();
    chk_out("ev6", 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk_out("async_rst", 1'b0, 1'b0);
    chk("async_rst.alarm_hh", bus.alarm_hh, 8'h06);
    chk("async_rst.alarm_mm", bus.alarm_mm, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
